// File: rtl/param_ni_pkg.sv
// Shared definitions for the parametrised network interface.
//   FLIT_*     : two-bit flit type codes carried in the top bits of every flit
//   tx_state_e : transmit packetiser states
//   rx_state_e : receive unpacker states
package param_ni_pkg;

  localparam logic [1:0] FLIT_IDLE = 2'b00;
  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_BODY = 2'b10;
  localparam logic [1:0] FLIT_TAIL = 2'b11;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_BODY = 2'd1,
    T_TAIL = 2'd2
  } tx_state_e;

  typedef enum logic [1:0] {
    R_HEAD = 2'd0,
    R_BODY = 2'd1,
    R_TAIL = 2'd2
  } rx_state_e;

endpackage

// File: rtl/ni_flit_fifo.sv
// Show-ahead synchronous flit FIFO.
//   clk, reset   : clock, asynchronous active-low reset (empties the FIFO)
//   wr_en/wr_data: push; ignored when full at the start of the cycle
//   rd_en/rd_data: pop; rd_data is the head entry, 0 while empty
//   full/empty/count : occupancy flags, registered
module ni_flit_fifo #(
  parameter  int W     = 48,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;

  // DEPTH is a power of two, so the count MSB alone marks full.
  assign full    = count_q[AW];
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // Full is judged on the start-of-cycle count: a same-cycle pop does not
  // open a slot for a push.
  assign push = wr_en & ~full;
  assign pop  = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; rd_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/param_network_interface.sv
// Network interface between a local word source/sink and a NoC router port.
//   TX: tx_data/tx_dest/tx_len/tx_valid/tx_ready -> head, body and tail flits
//       (tail carries XOR checksum) -> flit FIFO -> flit_out/_valid/_ready
//   RX: flit_in/_valid (never back-pressured) -> address filter, checksum
//       check -> rx_data/rx_valid, rx_src, rx_packet_end, rx_error, rx_drop
//   clk, reset : single clock, asynchronous active-low reset
module param_network_interface
  import param_ni_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FLIT_W     = 48,
  parameter int ADDR_W     = 8,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] LOCAL_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [ADDR_W-1:0] tx_dest,
  input  logic [LEN_W-1:0]  tx_len,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_out_valid,
  input  logic              flit_out_ready,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic              flit_in_valid,
  output logic              flit_in_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic [ADDR_W-1:0] rx_src,
  output logic              rx_packet_end,
  output logic              rx_error,
  output logic              rx_drop
);

  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  // Flit field placement: type on top, then dest/src/len MSB-first for heads;
  // body and tail keep their word in the low DATA_W bits.
  function automatic logic [FLIT_W-1:0] pack_head(input logic [ADDR_W-1:0] dest,
                                                  input logic [LEN_W-1:0]  len);
    logic [FLIT_W-1:0] f;
    f = '0;
    f[FLIT_W-1 -: 2]                = FLIT_HEAD;
    f[FLIT_W-3 -: ADDR_W]           = dest;
    f[FLIT_W-3-ADDR_W -: ADDR_W]    = LOCAL_ADDR;
    f[FLIT_W-3-2*ADDR_W -: LEN_W]   = len;
    return f;
  endfunction

  function automatic logic [FLIT_W-1:0] pack_word(input logic [1:0]        ftype,
                                                  input logic [DATA_W-1:0] word);
    logic [FLIT_W-1:0] f;
    f = '0;
    f[FLIT_W-1 -: 2] = ftype;
    f[DATA_W-1:0]    = word;
    return f;
  endfunction

  // ---------------------------------------------------------------- TX ----
  tx_state_e         tx_state_q, tx_state_d;
  logic [LEN_W-1:0]  tx_len_q, tx_len_d;
  logic [LEN_W-1:0]  tx_count_q, tx_count_d;
  logic [DATA_W-1:0] tx_csum_q, tx_csum_d;
  logic              fifo_wr;
  logic [FLIT_W-1:0] fifo_wdata;
  logic              fifo_full, fifo_empty;
  logic [FAW:0]      fifo_count_unused;

  // The head is written in the same cycle tx_dest is seen, so the
  // destination never needs to be held; only the length is kept.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_len_d   = tx_len_q;
    tx_count_d = tx_count_q;
    tx_csum_d  = tx_csum_q;
    fifo_wr    = 1'b0;
    fifo_wdata = '0;
    tx_ready   = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (tx_valid && !fifo_full) begin
          fifo_wr    = 1'b1;
          tx_len_d   = (tx_len == '0) ? LEN_ONE : tx_len;
          fifo_wdata = pack_head(tx_dest, tx_len_d);
          tx_count_d = '0;
          tx_csum_d  = '0;
          tx_state_d = T_BODY;
        end
      end
      T_BODY: begin
        tx_ready = !fifo_full;
        if (tx_valid && !fifo_full) begin
          fifo_wr    = 1'b1;
          fifo_wdata = pack_word(FLIT_BODY, tx_data);
          tx_csum_d  = tx_csum_q ^ tx_data;
          tx_count_d = tx_count_q + 1'b1;
          if (tx_count_q == tx_len_q - 1'b1) tx_state_d = T_TAIL;
        end
      end
      T_TAIL: begin
        if (!fifo_full) begin
          fifo_wr    = 1'b1;
          fifo_wdata = pack_word(FLIT_TAIL, tx_csum_q);
          tx_state_d = T_IDLE;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= T_IDLE;
      tx_len_q   <= '0;
      tx_count_q <= '0;
      tx_csum_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_len_q   <= tx_len_d;
      tx_count_q <= tx_count_d;
      tx_csum_q  <= tx_csum_d;
    end
  end

  ni_flit_fifo #(
    .W     (FLIT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (flit_out_ready),
    .rd_data (flit_out),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count_unused)
  );

  assign flit_out_valid = !fifo_empty;

  // ---------------------------------------------------------------- RX ----
  rx_state_e         rx_state_q, rx_state_d;
  logic [ADDR_W-1:0] rx_src_q, rx_src_d;
  logic [LEN_W-1:0]  rx_len_q, rx_len_d;
  logic [LEN_W-1:0]  rx_count_q, rx_count_d;
  logic [DATA_W-1:0] rx_csum_q, rx_csum_d;
  logic              rx_match_q, rx_match_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_end_q, rx_end_d;
  logic              rx_err_q, rx_err_d;
  logic              rx_drop_q, rx_drop_d;

  logic [1:0]        f_type;
  logic [ADDR_W-1:0] f_dest, f_src;
  logic [LEN_W-1:0]  f_len;
  logic [DATA_W-1:0] f_data;
  logic              f_accept, take_head, f_match;
  logic              rx_unused;

  assign f_type    = flit_in[FLIT_W-1 -: 2];
  assign f_dest    = flit_in[FLIT_W-3 -: ADDR_W];
  assign f_src     = flit_in[FLIT_W-3-ADDR_W -: ADDR_W];
  assign f_len     = flit_in[FLIT_W-3-2*ADDR_W -: LEN_W];
  assign f_data    = flit_in[DATA_W-1:0];
  assign f_accept  = flit_in_valid && (f_type != FLIT_IDLE);
  assign f_match   = (f_dest == LOCAL_ADDR) || (f_dest == '1);
  assign rx_unused = ^flit_in;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_src_d   = rx_src_q;
    rx_len_d   = rx_len_q;
    rx_count_d = rx_count_q;
    rx_csum_d  = rx_csum_q;
    rx_match_d = rx_match_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_end_d   = 1'b0;
    rx_err_d   = 1'b0;
    rx_drop_d  = 1'b0;
    take_head  = 1'b0;
    if (f_accept) begin
      case (rx_state_q)
        R_HEAD: begin
          if (f_type == FLIT_HEAD) take_head = 1'b1;
          else                     rx_err_d  = 1'b1;
        end
        R_BODY: begin
          case (f_type)
            FLIT_HEAD: begin
              rx_err_d  = 1'b1;
              take_head = 1'b1;
            end
            FLIT_BODY: begin
              rx_csum_d  = rx_csum_q ^ f_data;
              rx_count_d = rx_count_q + 1'b1;
              if (rx_match_q) begin
                rx_data_d  = f_data;
                rx_valid_d = 1'b1;
              end
              if (rx_count_d == rx_len_q) rx_state_d = R_TAIL;
            end
            default: begin
              rx_err_d   = 1'b1;
              rx_state_d = R_HEAD;
            end
          endcase
        end
        R_TAIL: begin
          case (f_type)
            FLIT_HEAD: begin
              rx_err_d  = 1'b1;
              take_head = 1'b1;
            end
            FLIT_TAIL: begin
              if (rx_match_q) begin
                rx_end_d = (f_data == rx_csum_q);
                rx_err_d = (f_data != rx_csum_q);
              end
              rx_state_d = R_HEAD;
            end
            default: begin
              rx_err_d   = 1'b1;
              rx_state_d = R_HEAD;
            end
          endcase
        end
        default: rx_state_d = R_HEAD;
      endcase
    end
    // A head always (re)starts a packet, whether expected or not.
    if (take_head) begin
      rx_src_d   = f_src;
      // A zero length would never terminate; handle it like the TX side does.
      rx_len_d   = (f_len == '0) ? LEN_ONE : f_len;
      rx_match_d = f_match;
      rx_count_d = '0;
      rx_csum_d  = '0;
      rx_drop_d  = !f_match;
      rx_state_d = R_BODY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q <= R_HEAD;
      rx_src_q   <= '0;
      rx_len_q   <= '0;
      rx_count_q <= '0;
      rx_csum_q  <= '0;
      rx_match_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_end_q   <= 1'b0;
      rx_err_q   <= 1'b0;
      rx_drop_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_src_q   <= rx_src_d;
      rx_len_q   <= rx_len_d;
      rx_count_q <= rx_count_d;
      rx_csum_q  <= rx_csum_d;
      rx_match_q <= rx_match_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_end_q   <= rx_end_d;
      rx_err_q   <= rx_err_d;
      rx_drop_q  <= rx_drop_d;
    end
  end

  assign flit_in_ready = 1'b1;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_src        = rx_src_q;
  assign rx_packet_end = rx_end_q;
  assign rx_error      = rx_err_q;
  assign rx_drop       = rx_drop_q;

endmodule

// File: tb/tb_param_network_interface.sv
// Scoreboard bench: stimulus pushes expected flits / RX events into queues,
// two negedge monitors pop and compare whenever the DUT presents output.
module tb_param_network_interface;

  localparam int FW = 48;
  localparam logic [7:0] LOC = 8'h05;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [15:0]   tx_data = '0;
  logic [7:0]    tx_dest = '0;
  logic [7:0]    tx_len = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [FW-1:0] flit_out;
  logic          flit_out_valid;
  logic          flit_out_ready = 1'b0;
  logic [FW-1:0] flit_in = '0;
  logic          flit_in_valid = 1'b0;
  logic          flit_in_ready;
  logic [15:0]   rx_data;
  logic          rx_valid;
  logic [7:0]    rx_src;
  logic          rx_packet_end;
  logic          rx_error;
  logic          rx_drop;

  always #5 clk = ~clk;

  param_network_interface #(
    .DATA_W(16), .FLIT_W(FW), .ADDR_W(8), .LEN_W(8), .FIFO_DEPTH(8), .LOCAL_ADDR(LOC)
  ) dut (
    .clk(clk), .reset(reset),
    .tx_data(tx_data), .tx_dest(tx_dest), .tx_len(tx_len), .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .flit_out(flit_out), .flit_out_valid(flit_out_valid), .flit_out_ready(flit_out_ready),
    .flit_in(flit_in), .flit_in_valid(flit_in_valid), .flit_in_ready(flit_in_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_src(rx_src),
    .rx_packet_end(rx_packet_end), .rx_error(rx_error), .rx_drop(rx_drop)
  );

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;      // 0: hold low, 1: hold high, 2: random
  int tx_words_acc = 0;

  // Receive-side observable: one entry per cycle in which any pulse is high.
  typedef struct packed {
    logic        v;
    logic        pe;
    logic        er;
    logic        dr;
    logic [15:0] data;
    logic [7:0]  src;
  } rx_ev_t;

  logic [FW-1:0] exp_tx_q[$];
  rx_ev_t        exp_rx_q[$];
  logic [FW-1:0] tx_e;
  rx_ev_t        rx_e, rx_got;

  // ---------------------------------------------------- reference model ----
  function automatic logic [FW-1:0] mk_head(input logic [7:0] d, input logic [7:0] s,
                                            input logic [7:0] l);
    logic [FW-1:0] f;
    f = '0;
    f[47:46] = 2'b01; f[45:38] = d; f[37:30] = s; f[29:22] = l;
    return f;
  endfunction

  function automatic logic [FW-1:0] mk_word(input logic [1:0] t, input logic [15:0] w);
    logic [FW-1:0] f;
    f = '0;
    f[47:46] = t; f[15:0] = w;
    return f;
  endfunction

  function automatic rx_ev_t mk_ev(input logic v, input logic pe, input logic er,
                                   input logic dr, input logic [15:0] d, input logic [7:0] s);
    rx_ev_t e;
    e.v = v; e.pe = pe; e.er = er; e.dr = dr; e.data = d; e.src = s;
    return e;
  endfunction

  function automatic logic [FW-1:0] rnd_flit();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[FW-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // ----------------------------------------------------------- monitors ----
  always @(negedge clk) begin
    if (reset && flit_out_valid && flit_out_ready) begin
      checks++;
      if (exp_tx_q.size() == 0) begin
        errors++;
        $display("FAIL tx_flit unexpected got %h expected none", flit_out);
      end else begin
        tx_e = exp_tx_q.pop_front();
        if (flit_out !== tx_e) begin
          errors++;
          $display("FAIL tx_flit got %h expected %h", flit_out, tx_e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset && (rx_valid || rx_packet_end || rx_error || rx_drop)) begin
      checks++;
      rx_got = mk_ev(rx_valid, rx_packet_end, rx_error, rx_drop,
                     rx_valid ? rx_data : 16'h0, rx_src);
      if (exp_rx_q.size() == 0) begin
        errors++;
        $display("FAIL rx_event unexpected got %h expected none", rx_got);
      end else begin
        rx_e = exp_rx_q.pop_front();
        if (rx_got !== rx_e) begin
          errors++;
          $display("FAIL rx_event got %h expected %h", rx_got, rx_e);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       flit_out_ready = 1'b0;
        1:       flit_out_ready = 1'b1;
        default: flit_out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ------------------------------------------------------------ drivers ----
  // Sends one packet on the word port; optionally pushes the model's flits.
  task automatic send_tx(input logic [7:0] dest, input logic [7:0] len,
                         input logic [15:0] words[$], input bit push_exp);
    int   leff;
    logic [15:0] cs;
    bit   got;
    leff = (len == 0) ? 1 : int'(len);
    cs = '0;
    if (push_exp) begin
      exp_tx_q.push_back(mk_head(dest, LOC, 8'(leff)));
      for (int i = 0; i < leff; i++) begin
        exp_tx_q.push_back(mk_word(2'b10, words[i]));
        cs ^= words[i];
      end
      exp_tx_q.push_back(mk_word(2'b11, cs));
    end
    tx_dest = dest; tx_len = len; tx_data = words[0]; tx_valid = 1'b1;
    for (int i = 0; i < leff; i++) begin
      got = 0;
      for (int c = 0; c < 400 && !got; c++) begin
        @(negedge clk);
        if (tx_ready) got = 1;
        @(posedge clk); #1;
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL tx_accept_timeout word %0d got no handshake expected one", i);
        break;
      end
      tx_words_acc++;
      // Header fields must be ignored once the packet has started.
      tx_dest = 8'($urandom); tx_len = 8'($urandom);
      if (i + 1 < leff) tx_data = words[i+1];
    end
    tx_valid = 1'b0;
  endtask

  task automatic rx_flit(input logic [FW-1:0] f);
    if ($urandom_range(0, 3) == 0) begin
      flit_in = rnd_flit();
      if ($urandom_range(0, 1) == 1) begin
        flit_in[47:46] = 2'b00;   // idle flit, valid
        flit_in_valid = 1'b1;
      end else begin
        flit_in_valid = 1'b0;     // anything, not valid
      end
      @(posedge clk); #1;
    end
    flit_in = f; flit_in_valid = 1'b1;
    @(posedge clk); #1;
    flit_in_valid = 1'b0;
  endtask

  task automatic rx_packet(input logic [7:0] dest, input logic [7:0] src,
                           input logic [15:0] words[$], input bit tail_ovr,
                           input logic [15:0] tail_v, input bit head_err);
    logic [15:0] cs;
    logic [15:0] tv;
    bit m;
    m = (dest == LOC) || (dest == 8'hFF);
    cs = '0;
    foreach (words[i]) cs ^= words[i];
    tv = tail_ovr ? tail_v : cs;
    if (head_err || !m) exp_rx_q.push_back(mk_ev(0, 0, head_err, !m, 16'h0, src));
    if (m) foreach (words[i]) exp_rx_q.push_back(mk_ev(1, 0, 0, 0, words[i], src));
    if (m) exp_rx_q.push_back(mk_ev(0, tv == cs, tv != cs, 0, 16'h0, src));
    rx_flit(mk_head(dest, src, 8'(words.size())));
    foreach (words[i]) rx_flit(mk_word(2'b10, words[i]));
    rx_flit(mk_word(2'b11, tv));
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 1000 && (exp_tx_q.size() != 0 || exp_rx_q.size() != 0); c++)
      @(posedge clk);
    #1;
    chk({name, "_tx_left"}, 64'(exp_tx_q.size()), 64'd0);
    chk({name, "_rx_left"}, 64'(exp_rx_q.size()), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_tx_ready"}, 64'(tx_ready), 64'd0);
    chk({name, "_flit_out"}, 64'(flit_out), 64'd0);
    chk({name, "_flit_out_valid"}, 64'(flit_out_valid), 64'd0);
    chk({name, "_flit_in_ready"}, 64'(flit_in_ready), 64'd1);
    chk({name, "_rx_data"}, 64'(rx_data), 64'd0);
    chk({name, "_rx_src"}, 64'(rx_src), 64'd0);
    chk({name, "_rx_pulses"}, 64'({rx_valid, rx_packet_end, rx_error, rx_drop}), 64'd0);
  endtask

  // --------------------------------------------------------------- main ----
  initial begin
    logic [15:0] w[$];
    logic [7:0]  d, s, l;
    logic [7:0]  dsel[4];

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed TX with literal expected flits.
    rdy_mode = 1;
    exp_tx_q.push_back(48'h4481_40C0_0000);
    exp_tx_q.push_back(48'h8000_0000_A5A5);
    exp_tx_q.push_back(48'h8000_0000_0F0F);
    exp_tx_q.push_back(48'h8000_0000_1234);
    exp_tx_q.push_back(48'hC000_0000_B89E);
    w = '{16'hA5A5, 16'h0F0F, 16'h1234};
    send_tx(8'h12, 8'd3, w, 1'b0);
    drain("tx_directed");

    // Length 0 behaves as a single-word packet.
    w = '{16'hBEEF};
    send_tx(8'h21, 8'd0, w, 1'b1);
    drain("tx_len0");

    // Router stalled: only FIFO_DEPTH flits (head + 7 words) may be taken.
    rdy_mode = 0;
    tx_words_acc = 0;
    w.delete();
    for (int i = 0; i < 10; i++) w.push_back(16'($urandom));
    fork
      send_tx(8'h33, 8'd10, w, 1'b1);
      begin
        repeat (40) @(posedge clk);
        #1;
        chk("stall_words_accepted", 64'(tx_words_acc), 64'd7);
        chk("stall_tx_ready", 64'(tx_ready), 64'd0);
        chk("stall_flit_out_valid", 64'(flit_out_valid), 64'd1);
        rdy_mode = 2;
      end
    join
    drain("tx_stall");

    // Random TX packets under random back-pressure.
    for (int p = 0; p < 20; p++) begin
      d = 8'($urandom);
      l = 8'($urandom_range(0, 12));
      w.delete();
      for (int i = 0; i < ((l == 0) ? 1 : int'(l)); i++) w.push_back(16'($urandom));
      send_tx(d, l, w, 1'b1);
    end
    drain("tx_random");

    // Directed RX.
    w = '{16'hA5A5, 16'h0F0F, 16'h1234};
    rx_packet(8'h05, 8'h05, w, 1'b1, 16'hB89E, 1'b0);
    drain("rx_good");
    chk("rx_src_after_good", 64'(rx_src), 64'h05);
    rx_packet(8'h05, 8'h05, w, 1'b1, 16'h0000, 1'b0);
    rx_packet(8'h07, 8'h41, w, 1'b1, 16'hB89E, 1'b0);
    rx_packet(8'hFF, 8'h42, w, 1'b1, 16'hB89E, 1'b0);
    drain("rx_variants");

    // Head after one body: error, then the new packet is received normally.
    exp_rx_q.push_back(mk_ev(1, 0, 0, 0, 16'h1111, 8'h51));
    rx_flit(mk_head(8'h05, 8'h51, 8'd3));
    rx_flit(mk_word(2'b10, 16'h1111));
    w = '{16'h2222, 16'h3333};
    rx_packet(8'h05, 8'h52, w, 1'b0, 16'h0, 1'b1);
    // Tail and body with no packet open: error only.
    exp_rx_q.push_back(mk_ev(0, 0, 1, 0, 16'h0, 8'h52));
    rx_flit(mk_word(2'b11, 16'h1234));
    exp_rx_q.push_back(mk_ev(0, 0, 1, 0, 16'h0, 8'h52));
    rx_flit(mk_word(2'b10, 16'h1234));
    // Tail before all bodies; extra body where a tail belongs.
    exp_rx_q.push_back(mk_ev(1, 0, 0, 0, 16'h4444, 8'h53));
    exp_rx_q.push_back(mk_ev(0, 0, 1, 0, 16'h0, 8'h53));
    rx_flit(mk_head(8'h05, 8'h53, 8'd2));
    rx_flit(mk_word(2'b10, 16'h4444));
    rx_flit(mk_word(2'b11, 16'h4444));
    exp_rx_q.push_back(mk_ev(1, 0, 0, 0, 16'h5555, 8'h54));
    exp_rx_q.push_back(mk_ev(0, 0, 1, 0, 16'h0, 8'h54));
    rx_flit(mk_head(8'h05, 8'h54, 8'd1));
    rx_flit(mk_word(2'b10, 16'h5555));
    rx_flit(mk_word(2'b10, 16'h6666));
    drain("rx_protocol");

    // Random RX packets.
    dsel = '{8'h05, 8'hFF, 8'h07, 8'h00};
    for (int p = 0; p < 15; p++) begin
      d = dsel[$urandom_range(0, 3)];
      if (d == 8'h00) d = 8'($urandom);
      s = 8'($urandom);
      w.delete();
      for (int i = 0; i < $urandom_range(1, 6); i++) w.push_back(16'($urandom));
      rx_packet(d, s, w, ($urandom_range(0, 3) == 0), 16'($urandom), 1'b0);
    end
    drain("rx_random");

    // Reset with both directions mid-packet.
    rdy_mode = 0;
    @(posedge clk); #1;
    tx_dest = 8'h12; tx_len = 8'd5; tx_data = 16'hAAAA; tx_valid = 1'b1;
    flit_in = mk_head(8'h05, 8'h33, 8'd3); flit_in_valid = 1'b1;
    @(posedge clk); #1;
    exp_rx_q.push_back(mk_ev(1, 0, 0, 0, 16'h7777, 8'h33));
    flit_in = mk_word(2'b10, 16'h7777);
    @(posedge clk); #1;
    flit_in_valid = 1'b0;
    tx_data = 16'hBBBB;
    @(posedge clk); #1;
    reset = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midreset");
    chk("midreset_rx_seen", 64'(exp_rx_q.size()), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    rdy_mode = 1;
    w = '{16'hC0DE, 16'hF00D};
    send_tx(8'h09, 8'd2, w, 1'b1);
    rx_packet(8'h05, 8'h66, w, 1'b0, 16'h0, 1'b0);
    drain("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
